pkt_class_demux: RTL and testbench
==================================

Name: pkt_class_demux

Overview:
Parametrised packet classifier/demultiplexer, the successor to the two-way agg/OQ parser. It accepts one AXI4-Stream input from the RX queue and buffers it in an internal fall-through FIFO. On the first beat it classifies each packet against NUM_OUTPUTS-1 runtime-programmable (ethertype, app-code) rules and streams the whole packet to exactly one of NUM_OUTPUTS master ports; port 0 is the default/OQ path. Per-port packet counters are provided.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width; tkeep width is /8
C_AXIS_TUSER_WIDTH, 128, tuser width
NUM_OUTPUTS, 4, number of master ports (2..8); rules exist for ports 1..NUM_OUTPUTS-1
FIFO_DEPTH_BITS, 6, input FIFO depth = 2^FIFO_DEPTH_BITS beats
ETHER_TYPE_POS, 96, LSB of 16-bit ethertype field in first beat
APP_CODE_POS, 112, LSB of app-code field in first beat
APP_CODE_WIDTH, 2, app-code field width; APP_CODE_POS+APP_CODE_WIDTH <= C_AXIS_DATA_WIDTH
CNT_WIDTH, 32, counter width

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per widths  slave stream
s_axis_tready  out  1  = ~fifo_nearly_full
m_axis_tdata/tkeep/tuser  out  NUM_OUTPUTS*width  flattened master buses, port i at slice i
m_axis_tvalid/tlast  out  NUM_OUTPUTS  per-port valid/last
m_axis_tready  in  NUM_OUTPUTS  per-port ready
cfg_rule_en  in  NUM_OUTPUTS-1  bit k enables rule for port k+1
cfg_ethertype  in  16*(NUM_OUTPUTS-1)  rule ethertype, slice k
cfg_appcode  in  APP_CODE_WIDTH*(NUM_OUTPUTS-1)  rule app code, slice k
cfg_match_and  in  1  1: rule needs ethertype AND appcode; 0: either
cfg_drop_nomatch  in  1  drop unmatched packets (PKT_CLASS_DROP_EN only)
pkt_in_cnt  out  CNT_WIDTH  packets accepted at input
pkt_out_cnt  out  NUM_OUTPUTS*CNT_WIDTH  packets completed per port
pkt_drop_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
- Reset (async assert, sync-released use): FIFO emptied, state IDLE, sel 0, all m_axis_tvalid 0, all counters 0. Reset mid-packet discards the partial packet with no tlast emitted.
- FIFO write = s_axis_tvalid & s_axis_tready. nearly_full asserts at 1 free entry.
- FSM IDLE: when the FIFO is non-empty, the head beat is the first beat. Compute the match vector; sel = the lowest-index enabled matching rule port, else 0. Register sel and the decision; next state is STREAM (or DROP). Config is sampled only in this cycle; changes mid-packet have no effect.
- STREAM: m_axis_tvalid[sel] = ~fifo_empty; all other tvalid are 0. Data, keep, user and last are driven to all slices from the FIFO head; only the sel slice is qualified. FIFO read = tvalid[sel] & tready[sel]. A handshake with tlast returns to IDLE.
- DROP: read every cycle while non-empty; a read with tlast increments pkt_drop_cnt and returns to IDLE.
- Latency: first beat is valid on its port 1 cycle after it reaches the FIFO head. There is 1 idle cycle between packets. No beat is duplicated or lost under arbitrary tready/tvalid gaps.
- tkeep is ignored for matching.
- Counters saturate at all-ones, no wrap. pkt_in_cnt increments on an input handshake with tlast. pkt_out_cnt[i] increments on a port-i handshake with tlast.

Optional Feature:
PKT_CLASS_DROP_EN: when defined, a packet with no match while cfg_drop_nomatch=1 enters DROP, is consumed silently and counted. When undefined, the DROP state and cfg_drop_nomatch are unused, pkt_drop_cnt is tied to 0, and unmatched packets go to port 0.

Test Plan:
- NUM_OUTPUTS=4, rule1 ethertype 0x8888 appcode 1 and_mode=1; send 3-beat pkt with 0x8888/1 -> only port1 tvalid, 3 beats, tlast on beat 3, pkt_out_cnt[1]=1.
- Same pkt with appcode 2, and_mode=1 -> routed to port0; and_mode=0 -> port1.
- Rules 1 and 2 both match -> port1 wins; port2 tvalid never asserts.
- Port1 tready toggles 1/0 every cycle, 10-beat pkt, input back-to-back -> output data identical, in order; s_axis_tready drops at nearly-full, no overflow.
- With PKT_CLASS_DROP_EN, cfg_drop_nomatch=1, unmatched 4-beat pkt followed by matching pkt -> no tvalid for the first, pkt_drop_cnt=1, second delivered intact.
- Assert axis_resetn=0 mid-packet (beat 2 of 5) -> all tvalid 0 immediately, counters 0; after release, a new packet routes correctly.

Source files
------------

// File: rtl/pkt_class_demux_if.sv
// AXI4-Stream bundle for pkt_class_demux; N ports share one flattened bus,
// port i occupying slice i of each field.
interface pkt_class_demux_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128,
    parameter int N      = 1
) ();
    logic [N*DATA_W-1:0]     tdata;
    logic [N*(DATA_W/8)-1:0] tkeep;
    logic [N*USER_W-1:0]     tuser;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_class_demux.sv
// Packet classifier/demux: buffers the input stream, classifies on the first beat and
// streams each packet to one master port. `define PKT_CLASS_DROP_EN enables the drop path.
module pkt_class_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                     cnt <= '0;
        else if (inc && cnt != {W{1'b1}}) cnt <= cnt + W'(1);
endmodule

module pkt_class_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_OUTPUTS        = 4,
    parameter int FIFO_DEPTH_BITS    = 6,
    parameter int ETHER_TYPE_POS     = 96,
    parameter int APP_CODE_POS       = 112,
    parameter int APP_CODE_WIDTH     = 2,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_resetn,
    pkt_class_demux_if.slave                          s_axis,
    pkt_class_demux_if.master                         m_axis,
    input  logic [NUM_OUTPUTS-2:0]                    cfg_rule_en,
    input  logic [16*(NUM_OUTPUTS-1)-1:0]             cfg_ethertype,
    input  logic [APP_CODE_WIDTH*(NUM_OUTPUTS-1)-1:0] cfg_appcode,
    input  logic                                      cfg_match_and,
    input  logic                                      cfg_drop_nomatch,
    output logic [CNT_WIDTH-1:0]                      pkt_in_cnt,
    output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]          pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]                      pkt_drop_cnt
);
    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_AXIS_TUSER_WIDTH;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int SEL_W = $clog2(NUM_OUTPUTS);
    localparam logic [FIFO_DEPTH_BITS:0] NF_LVL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    beat_t                      mem [DEPTH];
    beat_t                      head;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic                       fifo_empty, nearly_full, wr_en, rd_en;
    state_t                     state, state_nxt;
    logic [SEL_W-1:0]           sel, sel_nxt;
    logic [NUM_OUTPUTS-2:0]     match;
    logic                       hit;

    // Fall-through FIFO: the head entry is visible combinationally.
    assign fifo_empty    = (count == '0);
    assign nearly_full   = (count >= NF_LVL);
    assign s_axis.tready = ~nearly_full;
    assign wr_en         = s_axis.tvalid[0] & ~nearly_full;
    assign head          = mem[rd_ptr];

    always_ff @(posedge axis_aclk)
        if (wr_en) mem[wr_ptr] <= {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast[0]};

    always_ff @(posedge axis_aclk or negedge axis_resetn)
        if (!axis_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (rd_en) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (FIFO_DEPTH_BITS+1)'(1);
                default: ;
            endcase
        end

    for (genvar k = 0; k < NUM_OUTPUTS-1; k++) begin : g_rule
        logic eth_hit, app_hit;
        assign eth_hit  = head.data[ETHER_TYPE_POS +: 16] == cfg_ethertype[16*k +: 16];
        assign app_hit  = head.data[APP_CODE_POS +: APP_CODE_WIDTH] ==
                          cfg_appcode[APP_CODE_WIDTH*k +: APP_CODE_WIDTH];
        assign match[k] = cfg_rule_en[k] & (cfg_match_and ? (eth_hit & app_hit) : (eth_hit | app_hit));
    end

    // Descending scan so the lowest-index matching rule wins.
    always_comb begin
        sel_nxt = '0;
        hit     = 1'b0;
        for (int k = NUM_OUTPUTS-2; k >= 0; k--)
            if (match[k]) begin
                sel_nxt = SEL_W'(k + 1);
                hit     = 1'b1;
            end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn)
        if (!axis_resetn) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !fifo_empty) sel <= sel_nxt;
        end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
`ifdef PKT_CLASS_DROP_EN
                state_nxt = (!hit && cfg_drop_nomatch) ? DROP : STREAM;
`else
                state_nxt = STREAM;
`endif
            end
            STREAM: begin
                rd_en = m_axis.tready[sel] & ~fifo_empty;
                if (rd_en && head.last) state_nxt = IDLE;
            end
            DROP: begin
                rd_en = ~fifo_empty;
                if (rd_en && head.last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis.tvalid = '0;
        if (state == STREAM) m_axis.tvalid[sel] = ~fifo_empty;
    end

    assign m_axis.tdata = {NUM_OUTPUTS{head.data}};
    assign m_axis.tkeep = {NUM_OUTPUTS{head.keep}};
    assign m_axis.tuser = {NUM_OUTPUTS{head.user}};
    assign m_axis.tlast = {NUM_OUTPUTS{head.last}};

    logic [NUM_OUTPUTS-1:0]                out_inc;
    logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0] out_cnt;
    assign out_inc     = m_axis.tvalid & m_axis.tready & m_axis.tlast;
    assign pkt_out_cnt = out_cnt;

    pkt_class_sat_cnt #(.W(CNT_WIDTH)) u_in_cnt (
        .clk(axis_aclk), .rst_n(axis_resetn), .inc(wr_en & s_axis.tlast[0]), .cnt(pkt_in_cnt));

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out_cnt
        pkt_class_sat_cnt #(.W(CNT_WIDTH)) u_cnt (
            .clk(axis_aclk), .rst_n(axis_resetn), .inc(out_inc[i]), .cnt(out_cnt[i]));
    end

`ifdef PKT_CLASS_DROP_EN
    pkt_class_sat_cnt #(.W(CNT_WIDTH)) u_drop_cnt (
        .clk(axis_aclk), .rst_n(axis_resetn), .inc((state == DROP) & rd_en & head.last),
        .cnt(pkt_drop_cnt));
`else
    logic unused_drop;
    assign unused_drop  = &{1'b0, cfg_drop_nomatch, hit};
    assign pkt_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_class_demux.sv
// Scoreboard bench for pkt_class_demux: a rule-level reference model queues expected beats
// per port; an independent monitor checks every output beat and the input backpressure.
module tb_pkt_class_demux;
    localparam int DW = 256, UW = 128, KW = DW/8, NOUT = 4, FDB = 3, DEPTH = 1 << FDB;
    localparam int CW = 5, ETH_POS = 96, APP_POS = 112, APP_W = 2, CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_class_demux_if #(.DATA_W(DW), .USER_W(UW), .N(1))    s_axis ();
    pkt_class_demux_if #(.DATA_W(DW), .USER_W(UW), .N(NOUT)) m_axis ();

    logic [NOUT-2:0]            r_en;
    logic [NOUT-2:0][15:0]      r_eth;
    logic [NOUT-2:0][APP_W-1:0] r_app;
    logic                       r_and, r_drop;
    logic [CW-1:0]              in_cnt, drop_cnt;
    logic [NOUT-1:0][CW-1:0]    out_cnt;

    pkt_class_demux #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_OUTPUTS(NOUT),
        .FIFO_DEPTH_BITS(FDB), .ETHER_TYPE_POS(ETH_POS), .APP_CODE_POS(APP_POS),
        .APP_CODE_WIDTH(APP_W), .CNT_WIDTH(CW)
    ) dut (
        .axis_aclk(clk), .axis_resetn(rst_n), .s_axis(s_axis), .m_axis(m_axis),
        .cfg_rule_en(r_en), .cfg_ethertype(r_eth), .cfg_appcode(r_app),
        .cfg_match_and(r_and), .cfg_drop_nomatch(r_drop),
        .pkt_in_cnt(in_cnt), .pkt_out_cnt(out_cnt), .pkt_drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t exp_q [NOUT][$];
    beat_t pkt [$];
    int    n_chk = 0, n_fail = 0, occ = 0, full_seen = 0, rmode = 0;
    int    exp_in = 0, exp_drop = 0;
    int    exp_out [NOUT];

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(int n);
        return (n > CMAX) ? CW'(CMAX) : CW'(n);
    endfunction

    // Reference model: lowest enabled matching rule port, else default port 0 (or drop).
    function automatic int classify(logic [DW-1:0] d);
        logic [15:0]      et;
        logic [APP_W-1:0] ac;
        bit               e, a;
        et = d[ETH_POS +: 16];
        ac = d[APP_POS +: APP_W];
        for (int p = 1; p < NOUT; p++) begin
            e = (et == r_eth[p-1]);
            a = (ac == r_app[p-1]);
            if (r_en[p-1] && (r_and ? (e && a) : (e || a))) return p;
        end
`ifdef PKT_CLASS_DROP_EN
        if (r_drop) return -1;
`endif
        return 0;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < NOUT; p++) s += exp_q[p].size();
        return s;
    endfunction

    // Output-side monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            int    n_out;
            beat_t e;
            n_out = 0;
            chk("tvalid_onehot", DW'($countones(m_axis.tvalid) <= 1), 1);
            for (int p = 0; p < NOUT; p++) begin
                if (m_axis.tvalid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_tvalid: port %0d valid, required idle", p);
                    end else if (m_axis.tready[p]) begin
                        e = exp_q[p].pop_front();
                        chk("m_tdata", m_axis.tdata[p*DW +: DW], e.d);
                        chk("m_keep_user_last",
                            {m_axis.tkeep[p*KW +: KW], m_axis.tuser[p*UW +: UW], m_axis.tlast[p]},
                            {e.k, e.u, e.l});
                        n_out++;
                    end
                end
            end
`ifndef PKT_CLASS_DROP_EN
            chk("s_tready_vs_occupancy", DW'(s_axis.tready[0]), DW'(occ < DEPTH-1));
            occ += int'(s_axis.tvalid[0] & s_axis.tready[0]) - n_out;
`endif
            if (!s_axis.tready[0]) full_seen++;
        end
    end

    // Per-port ready pattern: 0 always, 1 random, 2 port1 toggles, 3 all stalled.
    initial begin
        logic [NOUT-1:0] tr;
        bit              tog = 1'b0;
        m_axis.tready = '1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       tr = NOUT'($urandom);
                2:       begin tr = '1; tr[1] = tog; tog = ~tog; end
                3:       tr = '0;
                default: tr = '1;
            endcase
            m_axis.tready = tr;
        end
    end

    task automatic build(int len, logic [15:0] eth, logic [APP_W-1:0] app);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom;
            for (int w = 0; w < UW/32; w++) b.u[w*32 +: 32] = $urandom;
            b.k = KW'($urandom);
            b.l = (i == len-1);
            if (i == 0) begin
                b.d[ETH_POS +: 16]   = eth;
                b.d[APP_POS +: APP_W] = app;
            end
            pkt.push_back(b);
        end
    endtask

    task automatic expect_pkt();
        int p;
        p = classify(pkt[0].d);
        exp_in++;
        if (p < 0) exp_drop++;
        else begin
            foreach (pkt[i]) exp_q[p].push_back(pkt[i]);
            exp_out[p]++;
        end
    endtask

    task automatic drive_beat(beat_t b);
        bit hs = 1'b0;
        int t  = 0;
        s_axis.tdata  = b.d;
        s_axis.tkeep  = b.k;
        s_axis.tuser  = b.u;
        s_axis.tlast  = b.l;
        s_axis.tvalid = 1'b1;
        while (!hs && t < 2000) begin
            @(negedge clk);
            hs = s_axis.tready[0];
            @(posedge clk);
            #1;
            t++;
        end
        s_axis.tvalid = 1'b0;
        if (!hs) begin
            n_chk++;
            n_fail++;
            $display("FAIL input_stall: s_tready low for %0d cycles, required a handshake", t);
        end
    endtask

    task automatic send(bit gaps);
        expect_pkt();
        foreach (pkt[i]) begin
            drive_beat(pkt[i]);
            if (gaps && $urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (pending() != 0 && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (pending() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still owed, required 0", pending());
        end
        repeat (DEPTH + 4) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt();
        chk("pkt_in_cnt", in_cnt, sat(exp_in));
        for (int p = 0; p < NOUT; p++) chk("pkt_out_cnt", out_cnt[p], sat(exp_out[p]));
        chk("pkt_drop_cnt", drop_cnt, sat(exp_drop));
    endtask

    initial begin
        logic [15:0] pool [4];
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tuser  = '0;
        r_en = '0; r_eth = '0; r_app = '0; r_and = 1'b1; r_drop = 1'b0;
        for (int p = 0; p < NOUT; p++) exp_out[p] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_s_tready", s_axis.tready, 1);
        check_cnt();
        @(posedge clk);
        #1;

        // Single rule, AND mode.
        r_en = 3'b001; r_eth[0] = 16'h8888; r_app[0] = 2'd1;
        build(3, 16'h8888, 2'd1); send(0); drain(); check_cnt();
        // App code mismatch: AND -> default port, OR -> rule port.
        build(3, 16'h8888, 2'd2); send(1); drain();
        r_and = 1'b0;
        build(3, 16'h8888, 2'd2); send(1); drain(); check_cnt();
        // Two matching rules: lower port wins.
        r_and = 1'b1; r_en = 3'b011; r_eth[1] = 16'h8888; r_app[1] = 2'd1;
        build(3, 16'h8888, 2'd1); send(0); drain(); check_cnt();
        // Toggling port1 ready with back-to-back input must fill the FIFO.
        rmode = 2; r_en = 3'b001; full_seen = 0;
        build(10, 16'h8888, 2'd1); send(0);
        build(10, 16'h8888, 2'd1); send(0);
        drain();
        chk("nearly_full_seen", DW'(full_seen != 0), 1);
        check_cnt();
        // Unmatched packet with drop requested, then a matching packet.
        rmode = 0; r_drop = 1'b1;
        build(4, 16'h1234, 2'd3); send(0);
        build(3, 16'h8888, 2'd1); send(0);
        drain(); check_cnt();

        // Randomised traffic; config only changes while the block is idle.
        pool[0] = 16'h8888; pool[1] = 16'h9999; pool[2] = 16'h0800; pool[3] = 16'h86dd;
        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 0) begin
                drain();
                r_en = 3'($urandom); r_and = 1'($urandom); r_drop = 1'($urandom);
                for (int k = 0; k < NOUT-1; k++) begin
                    r_eth[k] = pool[$urandom_range(3)];
                    r_app[k] = APP_W'($urandom);
                end
                rmode = $urandom_range(2);
            end
            build($urandom_range(6, 1), pool[$urandom_range(3)], APP_W'($urandom));
            send(1'($urandom));
        end
        drain(); check_cnt();

        // Reset in the middle of a packet held on port1.
        rmode = 3; r_en = 3'b001; r_and = 1'b1; r_drop = 1'b0;
        r_eth[0] = 16'h8888; r_app[0] = 2'd1;
        build(5, 16'h8888, 2'd1); expect_pkt();
        drive_beat(pkt[0]); drive_beat(pkt[1]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_tvalid", m_axis.tvalid, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_axis.tvalid, 0);
        chk("rst_mid_in_cnt", in_cnt, 0);
        chk("rst_mid_out_cnt", out_cnt, 0);
        for (int p = 0; p < NOUT; p++) begin
            exp_q[p].delete();
            exp_out[p] = 0;
        end
        occ = 0; exp_in = 0; exp_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; rmode = 0;
        build(3, 16'h8888, 2'd1); send(0); drain(); check_cnt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
